// File: rtl/uart_tx_ctrl.sv
// UART transmitter: start, 8 data bits LSB-first, optional parity, 1-2 stop bits, internal baud divider.
// Line is registered (start bit in the cycle after acceptance); tx_ready is low while busy, in reset, or while rx_int is high.
module uart_tx_ctrl #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       rx_int,
  output logic       rs232_tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CNT_W    = $clog2(BAUD_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BAUD_DIV - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             parity_bit;
  logic             stop_cnt;

  logic accept;
  logic bit_end;
  logic last_stop;

  assign tx_ready  = (state == IDLE) & ~rx_int & ~rst;
  assign accept    = tx_valid & tx_ready;
  assign bit_end   = (baud_cnt == CNT_LAST);
  assign last_stop = (STOP_BITS == 1) || stop_cnt;
  assign tx_busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= 3'd0;
      shift_reg  <= 8'h00;
      parity_bit <= 1'b0;
      stop_cnt   <= 1'b0;
      rs232_tx   <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      // Raised one count early so the pulse lands in the final cycle of the last stop bit.
      tx_done <= (state == STOP) && last_stop && (baud_cnt == CNT_PRE);

      if (state == IDLE || bit_end) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + CNT_ONE;
      end

      case (state)
        IDLE: begin
          rs232_tx <= 1'b1;
          if (accept) begin
            state      <= START;
            shift_reg  <= tx_data;
            parity_bit <= (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
            bit_idx    <= 3'd0;
            stop_cnt   <= 1'b0;
            rs232_tx   <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state    <= DATA;
            bit_idx  <= 3'd0;
            rs232_tx <= shift_reg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              if (PARITY_EN != 0) begin
                state    <= PARITY;
                rs232_tx <= parity_bit;
              end else begin
                state    <= STOP;
                rs232_tx <= 1'b1;
              end
            end else begin
              rs232_tx <= shift_reg[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            stop_cnt <= 1'b0;
            rs232_tx <= 1'b1;
          end
        end
        STOP: begin
          rs232_tx <= 1'b1;
          if (bit_end) begin
            if (last_stop) begin
              state    <= IDLE;
              stop_cnt <= 1'b0;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          rs232_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: three framing variants share one stimulus stream and are
// compared every cycle against a frame-level model (bit list x baud divider).
module tb_uart_tx_ctrl;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int DIV      = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic       rx_int = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [2:0] rdy, line, busy, done;

  int pe [3] = '{0, 1, 1};
  int po [3] = '{0, 0, 1};
  int sb [3] = '{1, 2, 2};

  logic        m_act  [3];
  logic [11:0] m_bits [3];
  int          m_nb   [3];
  int          m_pos  [3];
  int          done_at[3];
  int          cyc = 0;
  int          start_cyc;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_n (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(rdy[0]),
    .rx_int(rx_int), .rs232_tx(line[0]), .tx_busy(busy[0]), .tx_done(done[0]));

  uart_tx_ctrl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_e (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(rdy[1]),
    .rx_int(rx_int), .rs232_tx(line[1]), .tx_busy(busy[1]), .tx_done(done[1]));

  uart_tx_ctrl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_o (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(rdy[2]),
    .rx_int(rx_int), .rs232_tx(line[2]), .tx_busy(busy[2]), .tx_done(done[2]));

  task automatic check_bit(input string tag, input logic got, input logic exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: advance the model on the edge, then compare all outputs 1 time unit later.
  task automatic tick();
    logic        acc [3];
    logic [11:0] b;
    logic        e_line, e_done;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      acc[i] = !rst && tx_valid && !rx_int && !m_act[i];
      if (rst) begin
        m_act[i] = 1'b0;
      end else begin
        if (m_act[i]) begin
          m_pos[i]++;
          if (m_pos[i] == m_nb[i] * DIV) m_act[i] = 1'b0;
        end
        if (acc[i]) begin
          b = '1;
          b[0] = 1'b0;
          b[8:1] = tx_data;
          if (pe[i] != 0) b[9] = (po[i] != 0) ? ~^tx_data : ^tx_data;
          m_bits[i] = b;
          m_nb[i]   = 9 + pe[i] + sb[i];
          m_pos[i]  = 0;
          m_act[i]  = 1'b1;
        end
      end
    end
    cyc++;
    #1;
    for (int i = 0; i < 3; i++) begin
      e_line = m_act[i] ? m_bits[i][m_pos[i] / DIV] : 1'b1;
      e_done = m_act[i] && (m_pos[i] == m_nb[i] * DIV - 1);
      check_bit($sformatf("dut%0d line cyc%0d", i, cyc), line[i], e_line);
      check_bit($sformatf("dut%0d busy cyc%0d", i, cyc), busy[i], m_act[i]);
      check_bit($sformatf("dut%0d done cyc%0d", i, cyc), done[i], e_done);
      check_bit($sformatf("dut%0d ready cyc%0d", i, cyc), rdy[i], !m_act[i] && !rx_int && !rst);
      if (done[i] === 1'b1) done_at[i] = cyc;
    end
    @(negedge clk);
  endtask

  task automatic clear_done();
    for (int i = 0; i < 3; i++) done_at[i] = -1;
  endtask

  task automatic check_len(input string tag);
    for (int i = 0; i < 3; i++)
      check_int($sformatf("%s dut%0d frame length", tag, i), done_at[i] - start_cyc + 1,
                DIV * (10 + pe[i] + sb[i] - 1));
  endtask

  task automatic send_frame(input logic [7:0] d, input string tag);
    clear_done();
    tx_valid = 1'b1;
    tx_data  = d;
    tick();
    start_cyc = cyc;
    tx_valid  = 1'b0;
    tx_data   = 8'($urandom);
    repeat (130) tick();
    check_len(tag);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 1'b0; m_bits[i] = '1; m_nb[i] = 0; m_pos[i] = 0;
    end
    clear_done();

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();

    send_frame(8'h55, "basic55");
    send_frame(8'hA7, "parityA7");

    // Receiver busy: request is held off, then proceeds; rx_int mid-frame is ignored.
    clear_done();
    rx_int   = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    repeat (50) tick();
    rx_int = 1'b0;
    tick();
    start_cyc = cyc;
    tx_valid  = 1'b0;
    repeat (40) tick();
    rx_int = 1'b1;
    repeat (90) tick();
    check_len("rxhold3C");
    rx_int = 1'b0;
    repeat (3) tick();

    tx_valid = 1'b1;
    tx_data  = 8'h01;
    tick();
    tx_data = 8'hFF;
    repeat (250) tick();
    tx_valid = 1'b0;
    repeat (130) tick();

    // Reset during data bit 3 of a frame.
    clear_done();
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    tick();
    tx_valid = 1'b0;
    repeat (44) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++)
      check_int($sformatf("midreset dut%0d no done", i), done_at[i], -1);
    send_frame(8'h81, "after_reset81");

    repeat (3000) begin
      rst      = ($urandom_range(0, 999) == 0);
      tx_valid = ($urandom_range(0, 3) != 0);
      tx_data  = 8'($urandom);
      rx_int   = ($urandom_range(0, 15) == 0);
      tick();
    end
    rst      = 1'b0;
    tx_valid = 1'b0;
    rx_int   = 1'b0;
    repeat (130) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
